// File: rtl/mac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
// Saturating accumulation is selected at build time with MAC_SATURATE_EN.
package mac_pkg;

  localparam int DEFAULT_NUM_PIPELINE_STAGES = 4;
  // One output/accumulate register follows the product stages.
  localparam int DEFAULT_LATENCY = DEFAULT_NUM_PIPELINE_STAGES + 1;
  localparam int EXT_MAX_W = 256;

  typedef struct packed {
    logic valid;
    logic is_signed;
    logic acc;
  } sideband_t;

  function automatic int mac_latency(input int num_stages);
    return num_stages + 1;
  endfunction

  // Bits at and above prod_w are filled with the product sign (signed) or zero.
  function automatic logic [EXT_MAX_W-1:0] extend_product(
    input logic [EXT_MAX_W-1:0] prod,
    input int                   prod_w,
    input logic                 is_signed
  );
    logic [EXT_MAX_W-1:0] r;
    r = prod;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i >= prod_w) r[i] = is_signed & prod[prod_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_pipe_core.sv
// Signed/unsigned DATAWIDTH x DATAWIDTH multiplier with NUM_PIPELINE_STAGES
// stall-able registers and a sideband that travels with each product.
module mult_pipe_core
  import mac_pkg::*;
#(
  parameter int DATAWIDTH           = 16,
  parameter int NUM_PIPELINE_STAGES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  input  sideband_t                sb_in,
  output logic [2*DATAWIDTH-1:0]   product,
  output sideband_t                sb_out
);

  localparam int PW = 2 * DATAWIDTH;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic        [PW-1:0] prod_comb;

  logic [PW-1:0] prod_reg [NUM_PIPELINE_STAGES];
  sideband_t     sb_reg   [NUM_PIPELINE_STAGES];

  // Operands widened to the product width so one signed multiply covers both modes.
  assign a_ext     = {{DATAWIDTH{sb_in.is_signed & a[DATAWIDTH-1]}}, a};
  assign b_ext     = {{DATAWIDTH{sb_in.is_signed & b[DATAWIDTH-1]}}, b};
  assign prod_comb = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_reg[0] <= '0;
    end else if (en) begin
      sb_reg[0]   <= sb_in;
      prod_reg[0] <= prod_comb;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NUM_PIPELINE_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          sb_reg[gi] <= '0;
        end else if (en) begin
          sb_reg[gi]   <= sb_reg[gi-1];
          prod_reg[gi] <= prod_reg[gi-1];
        end
      end
    end
  endgenerate

  assign product = prod_reg[NUM_PIPELINE_STAGES-1];
  assign sb_out  = sb_reg[NUM_PIPELINE_STAGES-1];

endmodule

// File: rtl/pipelined_mac_unit.sv
// Streaming multiply / multiply-accumulate with valid/ready backpressure.
// Define MAC_SATURATE_EN for saturating accumulation with a sticky o_overflow.
module pipelined_mac_unit
  import mac_pkg::*;
#(
  parameter int DATAWIDTH           = 16,
  parameter int NUM_PIPELINE_STAGES = 4,
  parameter int ACCWIDTH            = 2 * DATAWIDTH + 8,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  input  logic                 i_signed,
  input  logic                 i_acc,
  output logic                 o_valid,
  input  logic                 out_ready,
  output logic [ACCWIDTH-1:0]  Z_final,
  output logic                 o_overflow
);

  localparam int PW = 2 * DATAWIDTH;

  generate
    if (DATAWIDTH < 2 || NUM_PIPELINE_STAGES < 1 || ACCWIDTH < PW || INSTANCE_ID < 0) begin : g_bad_params
      $error("pipelined_mac_unit: illegal parameter combination");
    end
  endgenerate

  logic                advance;
  sideband_t           sb_in;
  sideband_t           sb_out;
  logic [PW-1:0]       product;
  logic [ACCWIDTH-1:0] ext;
  logic [ACCWIDTH-1:0] next_acc;
  logic [ACCWIDTH-1:0] acc_reg;
  logic                o_valid_reg;

  // A full output register that is not being drained freezes the whole pipe.
  assign advance  = !o_valid_reg || out_ready;
  assign in_ready = advance;
  assign sb_in    = '{valid: i_valid, is_signed: i_signed, acc: i_acc};

  mult_pipe_core #(
    .DATAWIDTH          (DATAWIDTH),
    .NUM_PIPELINE_STAGES(NUM_PIPELINE_STAGES)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .a      (A),
    .b      (B),
    .sb_in  (sb_in),
    .product(product),
    .sb_out (sb_out)
  );

`ifdef MAC_SATURATE_EN
  logic                clamp;
  logic                carry;
  logic [ACCWIDTH-1:0] sum;
  logic                overflow_reg;

  always_comb begin
    ext      = ACCWIDTH'(extend_product(EXT_MAX_W'(product), PW, sb_out.is_signed));
    {carry, sum} = {1'b0, acc_reg} + {1'b0, ext};
    next_acc = sum;
    clamp    = 1'b0;
    if (!sb_out.acc) begin
      next_acc = ext;
    end else if (sb_out.is_signed) begin
      // Signed overflow: like-signed addends yielding a differently-signed sum.
      if (acc_reg[ACCWIDTH-1] == ext[ACCWIDTH-1] && sum[ACCWIDTH-1] != acc_reg[ACCWIDTH-1]) begin
        clamp    = 1'b1;
        next_acc = acc_reg[ACCWIDTH-1] ? {1'b1, {(ACCWIDTH-1){1'b0}}}
                                       : {1'b0, {(ACCWIDTH-1){1'b1}}};
      end
    end else if (carry) begin
      clamp    = 1'b1;
      next_acc = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (advance && sb_out.valid) begin
      overflow_reg <= sb_out.acc ? (overflow_reg | clamp) : 1'b0;
    end
  end

  assign o_overflow = overflow_reg;
`else
  always_comb begin
    ext      = ACCWIDTH'(extend_product(EXT_MAX_W'(product), PW, sb_out.is_signed));
    next_acc = sb_out.acc ? (acc_reg + ext) : ext;
  end

  assign o_overflow = 1'b0;
`endif

  // The accumulator doubles as the result register: Z_final always shows acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_reg <= 1'b0;
      acc_reg     <= '0;
    end else if (advance) begin
      o_valid_reg <= sb_out.valid;
      if (sb_out.valid) acc_reg <= next_acc;
    end
  end

  assign o_valid = o_valid_reg;
  assign Z_final = acc_reg;

endmodule

// File: doc/pipelined_mac_unit.md
Name: pipelined_mac_unit

Overview:
Parametrised successor to the fixed-mode array multiplier wrapper. Provides a DATAWIDTH x DATAWIDTH multiplier with a configurable pipeline depth and a per-transaction signed/unsigned mode. Adds an accumulate mode and valid/ready backpressure. Sits in the datapath wherever a streaming multiply or multiply-accumulate is needed, and serves as the retiming target for the multiplier pipeline.

Parameters:
DATAWIDTH, 16, operand width in bits (>=2)
NUM_PIPELINE_STAGES, 4, registered product stages (>=1)
ACCWIDTH, 2*DATAWIDTH+8, accumulator/result width (>=2*DATAWIDTH)
INSTANCE_ID, 0, identifier for synthesis/retiming scripts; no functional effect

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  input transaction valid
in_ready  out  1  unit can accept input this cycle
A  in  DATAWIDTH  operand A
B  in  DATAWIDTH  operand B
i_signed  in  1  1 = two's-complement operands, 0 = unsigned
i_acc  in  1  1 = add product to accumulator, 0 = start new sum with product
o_valid  out  1  Z_final valid
out_ready  in  1  downstream accepts Z_final
Z_final  out  ACCWIDTH  product or accumulated sum
o_overflow  out  1  accumulation overflow flag (see Optional Feature)

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. On rst: all stage valid bits=0, o_valid=0, Z_final=0, accumulator=0, o_overflow=0. In-flight data is discarded; no stale result ever emerges after reset.
- Pipeline: NUM_PIPELINE_STAGES product stages plus one output/accumulate stage. i_signed and i_acc travel as sideband alongside the product.
- Latency: an input accepted in cycle t produces o_valid in cycle t+NUM_PIPELINE_STAGES+1 when there is no stall.
- Global stall: advance = !o_valid || out_ready. in_ready = advance (combinational). Transfer occurs when i_valid && in_ready.
- When advance=0, every stage holds, and Z_final/o_valid stay stable. Bubbles are not compressed.
- Product: full 2*DATAWIDTH bits. Sign-extended to ACCWIDTH when i_signed=1, zero-extended otherwise.
- Output stage, triggered only on a valid item with advance=1:
  - i_acc=0: acc <= ext(product).
  - i_acc=1: acc <= acc + ext(product), modulo 2^ACCWIDTH.
  - Z_final <= the new acc value.
- Invalid items in the output stage leave acc and Z_final unchanged.
- i_acc=1 as the first item after reset accumulates onto 0.
- Mixed i_signed within one accumulation is allowed; each product is extended per its own flag.
- Throughput: one result per cycle while out_ready=1.

Optional Feature:
Macro MAC_SATURATE_EN.
- Defined: accumulation saturates. If i_signed=1, clamp to the signed ACCWIDTH max/min. If i_signed=0, clamp to all-ones. o_overflow goes to 1 on the output cycle where clamping occurred and is sticky until an i_acc=0 item reaches the output stage or rst.
- Undefined: accumulation wraps and o_overflow is tied to 0.

Decomposition:
- Package mac_pkg: a function for sign/zero extension to ACCWIDTH; a typedef for the sideband struct {valid, signed, acc}; localparams for latency (NUM_PIPELINE_STAGES+1).
- Sub-module mult_pipe_core: a signed/unsigned multiplier with NUM_PIPELINE_STAGES registers, a stall enable, and a sideband pass-through.
- pipelined_mac_unit itself: stall logic, output/accumulate stage, saturation.

Test Plan:
Defaults are DATAWIDTH=16, NUM_PIPELINE_STAGES=4, ACCWIDTH=40, latency 5, unless a case says otherwise.
- Unsigned: A=0xFFFF, B=0xFFFF, i_signed=0, i_acc=0 -> 5 cycles later o_valid=1, Z_final=0x00FFFE0001.
- Signed: A=0xFFFF, B=0x0002, i_signed=1, i_acc=0 -> Z_final=0xFFFFFFFFFE (-2).
- Accumulate, back-to-back: (3,4,acc0), (5,6,acc1), (7,8,acc1) -> Z_final 12, 42, 98 on three consecutive cycles.
- Backpressure: hold out_ready=0 for 3 cycles while o_valid=1 -> Z_final and o_valid are held, in_ready=0, and no items are lost. After release, the remaining results arrive in order, one per cycle.
- Reset mid-flight: assert rst with 3 items in flight -> next cycle o_valid=0 and Z_final=0. No result appears in the following 10 cycles.
- Overflow, with ACCWIDTH=32, signed: 0x7FFF*0x7FFF sent three times as (acc0, acc1, acc1).
  - With MAC_SATURATE_EN: third Z_final=0x7FFFFFFF, o_overflow=1.
  - Without MAC_SATURATE_EN: third Z_final=0xBFFD0003, o_overflow=0.
